// File: rtl/vga_fb_arbiter.sv
// Frame-buffer arbiter: display reads the front bank, the writer fills the back bank.
// Banks swap on the vsync fall that follows a completed frame.
module vga_fb_arbiter #(
  parameter int IMG_W = 320,
  parameter int IMG_H = 240,
  parameter int AW    = 17,
  parameter int DW    = 8
) (
  input  logic          pclk,
  input  logic          reset,
  input  logic          valid,
  input  logic [9:0]    h_cnt,
  input  logic [9:0]    v_cnt,
  input  logic          hsync_in,
  input  logic          vsync_in,
  input  logic          wr_req,
  input  logic [AW-1:0] wr_addr,
  input  logic [DW-1:0] wr_data,
  output logic          wr_gnt,
  input  logic          frame_done,
  output logic          swap_done,
  output logic          front_bank,
  output logic          mem_en,
  output logic          mem_we,
  output logic [AW:0]   mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata,
  output logic          pix_valid,
  output logic [DW-1:0] pix_data,
  output logic          hsync_out,
  output logic          vsync_out
);

  typedef enum logic {SHOW = 1'b0, PEND = 1'b1} state_t;

  localparam logic [AW:0] NPIX = (AW+1)'(IMG_W * IMG_H);

  state_t        state_q, state_d;
  logic          front_q, front_d;
  logic          swap_q, swap_d;
  logic          pv_q, pv_d;
  logic          hs_q, hs_d;
  logic          vs_q, vs_d;
  logic          img_q, img_d;
  logic          in_img;
  logic          wr_ok;
  logic          vs_fall;
  logic [AW-1:0] rd_off;

  always_comb begin
    in_img = valid
           & (32'(h_cnt) < 32'(IMG_W))
           & (32'(v_cnt) < 32'(IMG_H));
    rd_off = AW'(32'(v_cnt) * 32'(IMG_W)
           + 32'(h_cnt));
    wr_ok   = {1'b0, wr_addr} < NPIX;
    vs_fall = vs_q & ~vsync_in;
  end

  // Reads never stall; out-of-range writes are acked but dropped.
  always_comb begin
    wr_gnt = reset & wr_req & ~in_img
           & (state_q == SHOW);
    mem_en = reset & (in_img | (wr_gnt & wr_ok));
    mem_we = reset & wr_gnt & wr_ok;
    mem_addr = in_img ? {front_q, rd_off}
                      : {~front_q, wr_addr};
    mem_wdata = wr_data;
  end

  always_comb begin
    state_d = state_q;
    front_d = front_q;
    swap_d  = 1'b0;
    pv_d    = valid;
    hs_d    = hsync_in;
    vs_d    = vsync_in;
    img_d   = in_img;
    unique case (state_q)
      SHOW: begin
        if (frame_done) state_d = PEND;
      end
      PEND: begin
        if (vs_fall) begin
          state_d = SHOW;
          front_d = ~front_q;
          swap_d  = 1'b1;
        end
      end
      default: state_d = SHOW;
    endcase
  end

  always_ff @(posedge pclk or negedge reset) begin
    if (!reset) begin
      state_q <= SHOW;
      front_q <= 1'b0;
      swap_q  <= 1'b0;
      pv_q    <= 1'b0;
      hs_q    <= 1'b0;
      vs_q    <= 1'b0;
      img_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      front_q <= front_d;
      swap_q  <= swap_d;
      pv_q    <= pv_d;
      hs_q    <= hs_d;
      vs_q    <= vs_d;
      img_q   <= img_d;
    end
  end

  assign front_bank = front_q;
  assign swap_done  = swap_q;
  assign pix_valid  = pv_q;
  assign hsync_out  = hs_q;
  assign vsync_out  = vs_q;
  assign pix_data   = img_q ? mem_rdata : '0;

endmodule

// File: doc/vga_fb_arbiter.md
Name: vga_fb_arbiter

Overview:
- Shares one single-port synchronous frame-buffer RAM between two requesters: the VGA display read path, driven by the 640x480 timing generator's valid/h_cnt/v_cnt, and the edge-detector result writer.
- Double-buffers the image: display reads the front bank while the writer fills the back bank.
- Swaps banks at a vertical-sync boundary.
- Re-times hsync/vsync so they stay aligned with the 1-cycle RAM read latency.

Parameters:
IMG_W, 320, displayed image width in pixels (top-left of the active area)
IMG_H, 240, displayed image height in lines
AW, 17, per-bank address width; must satisfy IMG_W*IMG_H <= 2^AW
DW, 8, pixel data width

Ports:
pclk  in  1  pixel clock
reset  in  1  asynchronous, active-low reset
valid  in  1  active-video flag from the timing generator
h_cnt  in  10  active-area column, 0..639
v_cnt  in  10  active-area line, 0..479
hsync_in  in  1  timing-generator hsync (active-low pulse)
vsync_in  in  1  timing-generator vsync (active-low pulse)
wr_req  in  1  writer request; wr_addr and wr_data are held until granted
wr_addr  in  AW  back-bank pixel address
wr_data  in  DW  pixel to write
wr_gnt  out  1  write accepted this cycle (combinational)
frame_done  in  1  1-cycle pulse: back bank holds a complete frame
swap_done  out  1  1-cycle pulse: banks swapped
front_bank  out  1  bank currently displayed
mem_en  out  1  RAM enable
mem_we  out  1  RAM write enable
mem_addr  out  AW+1  {bank, offset}
mem_wdata  out  DW  RAM write data
mem_rdata  in  DW  RAM read data, valid 1 cycle after a read is enabled
pix_valid  out  1  valid delayed by 1 cycle
pix_data  out  DW  display pixel, aligned with pix_valid
hsync_out  out  1  hsync_in delayed by 1 cycle
vsync_out  out  1  vsync_in delayed by 1 cycle

Behaviour:
- Reset: reset is asynchronous, active-low; clock is pclk. While reset is low:
  - state=SHOW, front_bank=0, swap_done=0.
  - pix_valid=0, hsync_out=0, vsync_out=0, and the internal in_img_d=0 and vsync_d=0.
  - Combinational outputs are forced low: mem_en, mem_we, wr_gnt.
  - Reset mid-frame discards any pending swap.
- Display read:
  - in_img = valid & (h_cnt < IMG_W) & (v_cnt < IMG_H).
  - When in_img=1: mem_en=1, mem_we=0, mem_addr = {front_bank, v_cnt*IMG_W + h_cnt}, truncated to AW bits.
  - Display reads have absolute priority and are never stalled.
- Output pipeline, 1-cycle latency:
  - pix_valid, hsync_out, vsync_out and in_img_d are registered copies of valid, hsync_in, vsync_in and in_img.
  - pix_data = in_img_d ? mem_rdata : 0.
- Write grant:
  - wr_gnt = wr_req & ~in_img & (state==SHOW).
  - When granted: mem_en=1, mem_we=1, mem_addr = {~front_bank, wr_addr}, mem_wdata=wr_data.
  - A write with wr_addr >= IMG_W*IMG_H is still granted, but mem_en stays 0 and the data is discarded.
  - When nothing is active, mem_en=0 and mem_we=0.
- Swap FSM:
  - SHOW: frame_done=1 moves to PEND. A write requested in the same cycle as frame_done is still arbitrated as SHOW.
  - PEND: wr_gnt is held at 0, so the completed frame is protected. frame_done is ignored.
  - vs_fall = vsync_d & ~vsync_in.
  - In PEND with vs_fall=1: toggle front_bank, pulse swap_done, return to SHOW.
  - vs_fall while in SHOW has no effect. A frame_done that coincides with vs_fall therefore swaps at the next vsync fall.
- Bank use after a swap: the new front_bank applies to reads from the next cycle. Writes target the new back bank.

Test Plan:
- Reset low mid-frame -> all outputs 0 and front_bank=0. Release reset -> first vs_fall causes no swap.
- valid=1, h_cnt=5, v_cnt=2 -> mem_en=1, mem_we=0, mem_addr={0,645}. Next cycle pix_valid=1 and pix_data=mem_rdata (drive 0xA5, expect 0xA5).
- valid=1, h_cnt=400, v_cnt=10, wr_req=1, wr_addr=100, wr_data=0x3C -> wr_gnt=1, mem_we=1, mem_addr={1,100}. Next cycle pix_valid=1, pix_data=0.
- wr_req held while h_cnt sweeps 300..320 inside the image -> wr_gnt=0 until h_cnt=320, then granted exactly once. wr_addr=76800 -> wr_gnt=1 with mem_en=0.
- frame_done pulse at line 100 -> wr_gnt=0 until the vsync_in fall. On that cycle front_bank goes 0->1 and swap_done=1. The next write drives mem_addr MSB=0.
- frame_done coincident with a vsync_in fall -> no swap that cycle. Swap occurs 420000 cycles later, at the next fall.
